// File: rtl/fwd_pkg.sv
// Shared definitions for the hazard/forwarding controller.
// Holds the EX operand-mux select codes and the hold-FSM state encodings.
package fwd_pkg;

    localparam int unsigned FWD_SEL_W = 2;

    // EX operand mux select: register file, EX/MEM, MEM/WB, post-WB history
    typedef enum logic [FWD_SEL_W-1:0] {
        FWD_RF   = 2'b00,
        FWD_MEM  = 2'b01,
        FWD_WB   = 2'b10,
        FWD_HIST = 2'b11
    } fwd_sel_e;

    // Multi-cycle EX hold FSM
    typedef enum logic {
        S_RUN     = 1'b0,
        S_MD_BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/fwd_src_match.sv
// Forwarding select for one EX source operand.
// Ports:
//   src               EX source register address
//   mem_dst / mem_we  EX/MEM writer
//   wb_dst  / wb_we   MEM/WB writer
//   hist_dst/ hist_we one-deep post-WB history writer
//   sel               mux select (youngest matching writer wins; r0 never forwards)
module fwd_src_match
    import fwd_pkg::*;
#(
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned HIST_EN = 1
) (
    input  logic [ADDR_W-1:0]    src,
    input  logic [ADDR_W-1:0]    mem_dst,
    input  logic                 mem_we,
    input  logic [ADDR_W-1:0]    wb_dst,
    input  logic                 wb_we,
    input  logic [ADDR_W-1:0]    hist_dst,
    input  logic                 hist_we,
    output logic [FWD_SEL_W-1:0] sel
);

    // Priority: EX/MEM, then MEM/WB, then history
    always_comb begin
        sel = FWD_RF;
        if (src != '0) begin
            if (mem_we && (mem_dst == src)) begin
                sel = FWD_MEM;
            end else if (wb_we && (wb_dst == src)) begin
                sel = FWD_WB;
            end else if ((HIST_EN != 0) && hist_we && (hist_dst == src)) begin
                sel = FWD_HIST;
            end
        end
    end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Hazard / forwarding controller for the 5-stage pipeline.
// Produces per-operand forwarding selects for the EX muxes, detects load-use
// hazards, and holds EX for the duration of a multi-cycle (mul/div) op.
// Ports:
//   clk_i, rst_i (async, active-low)
//   ex_src_i / id_src_i / id_src_vld_i   packed source registers, src k at [k*ADDR_W +: ADDR_W]
//   ex_dst_i, ex_memread_i, ex_md_start_i EX instruction info
//   mem_dst_i/mem_regwrite_i, wb_dst_i/wb_regwrite_i  downstream writers
//   flush_i                               squash the EX instruction
//   fwd_sel_o                             2 bits per source
//   fe_stall_o, idex_bubble_o, ex_hold_o  pipeline control (combinational)
//   md_busy_o                             registered: FSM in MD_BUSY
module hazard_forward_ctrl
    import fwd_pkg::*;
#(
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned MD_LAT  = 4,
    parameter int unsigned HIST_EN = 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NUM_SRC*ADDR_W-1:0]   ex_src_i,
    input  logic [NUM_SRC*ADDR_W-1:0]   id_src_i,
    input  logic [NUM_SRC-1:0]          id_src_vld_i,
    input  logic [ADDR_W-1:0]           ex_dst_i,
    input  logic                        ex_memread_i,
    input  logic                        ex_md_start_i,
    input  logic [ADDR_W-1:0]           mem_dst_i,
    input  logic                        mem_regwrite_i,
    input  logic [ADDR_W-1:0]           wb_dst_i,
    input  logic                        wb_regwrite_i,
    input  logic                        flush_i,
    output logic [FWD_SEL_W*NUM_SRC-1:0] fwd_sel_o,
    output logic                        fe_stall_o,
    output logic                        idex_bubble_o,
    output logic                        ex_hold_o,
    output logic                        md_busy_o
);

    localparam int unsigned CNT_W = $clog2(MD_LAT) + 1;

    state_e             state_q;
    state_e             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               hist_we_q;
    logic [ADDR_W-1:0]  hist_dst_q;
    logic               load_use;

    // Post-WB history: WB always drains, so this updates on every clock
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            hist_we_q  <= 1'b0;
            hist_dst_q <= '0;
        end else begin
            hist_we_q  <= wb_regwrite_i;
            hist_dst_q <= wb_dst_i;
        end
    end

    // One forwarding matcher per EX source
    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        fwd_src_match #(
            .ADDR_W  (ADDR_W),
            .HIST_EN (HIST_EN)
        ) u_match (
            .src      (ex_src_i[k*ADDR_W +: ADDR_W]),
            .mem_dst  (mem_dst_i),
            .mem_we   (mem_regwrite_i),
            .wb_dst   (wb_dst_i),
            .wb_we    (wb_regwrite_i),
            .hist_dst (hist_dst_q),
            .hist_we  (hist_we_q),
            .sel      (fwd_sel_o[k*FWD_SEL_W +: FWD_SEL_W])
        );
    end

    // Load in EX whose destination is read by the instruction in ID
    always_comb begin
        load_use = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (id_src_vld_i[k] && (id_src_i[k*ADDR_W +: ADDR_W] == ex_dst_i)) begin
                load_use = 1'b1;
            end
        end
        load_use = load_use && ex_memread_i && (ex_dst_i != '0);
    end

    // State, counter and busy flag
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= S_RUN;
            cnt_q     <= '0;
            md_busy_o <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            md_busy_o <= (state_d == S_MD_BUSY);
        end
    end

    // Next state and stall outputs; the start cycle itself is the first hold cycle
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        fe_stall_o    = 1'b0;
        idex_bubble_o = 1'b0;
        ex_hold_o     = 1'b0;
        unique case (state_q)
            S_RUN: begin
                if (!flush_i) begin
                    if (ex_md_start_i) begin
                        if (MD_LAT > 1) begin
                            fe_stall_o = 1'b1;
                            ex_hold_o  = 1'b1;
                            state_d    = S_MD_BUSY;
                            cnt_d      = CNT_W'(MD_LAT - 1);
                        end
                    end else if (load_use) begin
                        fe_stall_o    = 1'b1;
                        idex_bubble_o = 1'b1;
                    end
                end
            end
            S_MD_BUSY: begin
                if (flush_i) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else begin
                    fe_stall_o = (cnt_q > CNT_W'(1));
                    ex_hold_o  = (cnt_q > CNT_W'(1));
                    cnt_d      = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_RUN;
                    end
                end
            end
            default: begin
                state_d = S_RUN;
                cnt_d   = '0;
            end
        endcase
        // No pipeline control while in reset
        if (!rst_i) begin
            fe_stall_o    = 1'b0;
            idex_bubble_o = 1'b0;
            ex_hold_o     = 1'b0;
        end
    end

endmodule
